// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
// A tie goes to whichever port was not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  cpu_req,
  input  logic  dma_req,
  input  port_t last_grant,
  output port_t grant
);

  always_comb begin
    grant = PORT_CPU;
    if (cpu_req && dma_req) begin
      grant = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (dma_req) begin
      grant = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a DMA port onto one single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the CPU has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_AW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [15:0]       dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Only meaningful when WAIT_STATES > 0; the WAIT state is skipped otherwise.
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES - 1);

  state_t              state_reg;
  port_t               winner_reg;
  logic                we_reg;
  logic [MEM_AW-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [1:0]          wait_cnt_reg;
  logic                cpu_ack_reg;
  logic                dma_ack_reg;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [DATA_W-1:0]   cpu_rdata_reg;
  logic [DATA_W-1:0]   dma_rdata_reg;
  port_t               grant;
  port_t               last_grant;
  logic                any_req;

  assign any_req = cpu_req || dma_req;

  mem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef MEM_ARB_RR_EN
  port_t last_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= PORT_CPU;
    end else if (state_reg == IDLE && any_req) begin
      last_reg <= grant;
    end
  end

  assign last_grant = last_reg;
`else
  // Pretending DMA always won last makes the picker hand every tie to the CPU.
  assign last_grant = PORT_DMA;
`endif

  generate
    if (MEM_AW < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{cpu_addr[15:MEM_AW], dma_addr[15:MEM_AW]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      winner_reg    <= PORT_CPU;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wait_cnt_reg  <= 2'd0;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
    end else begin
      cpu_ack_reg <= 1'b0;
      dma_ack_reg <= 1'b0;
      mem_en_reg  <= 1'b0;
      mem_we_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            winner_reg <= grant;
            we_reg     <= (grant == PORT_CPU) ? cpu_we : dma_we;
            addr_reg   <= (grant == PORT_CPU) ? cpu_addr[MEM_AW-1:0] : dma_addr[MEM_AW-1:0];
            wdata_reg  <= (grant == PORT_CPU) ? cpu_wdata : dma_wdata;
            mem_en_reg <= 1'b1;
            mem_we_reg <= (grant == PORT_CPU) ? cpu_we : dma_we;
            state_reg  <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt_reg <= 2'd0;
          if (WAIT_STATES > 0) begin
            state_reg <= WAIT;
          end else begin
            cpu_ack_reg <= (winner_reg == PORT_CPU);
            dma_ack_reg <= (winner_reg == PORT_DMA);
            state_reg   <= DONE;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            cpu_ack_reg <= (winner_reg == PORT_CPU);
            dma_ack_reg <= (winner_reg == PORT_DMA);
            state_reg   <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end
        DONE: begin
          // RAM output has been stable since the cycle after ACCESS.
          if (!we_reg && winner_reg == PORT_CPU) cpu_rdata_reg <= mem_rdata;
          if (!we_reg && winner_reg == PORT_DMA) dma_rdata_reg <= mem_rdata;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign dma_ack   = dma_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_rdata = dma_rdata_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench: instance A uses WAIT_STATES=0, instance B WAIT_STATES=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance A (no wait states)
  logic        reset_a;
  logic        cpu_req_a, cpu_we_a, dma_req_a, dma_we_a;
  logic [15:0] cpu_addr_a, dma_addr_a;
  logic [7:0]  cpu_wdata_a, dma_wdata_a;
  logic        cpu_ack_a, dma_ack_a, mem_en_a, mem_we_a, busy_a;
  logic [7:0]  cpu_rdata_a, dma_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

  // Instance B (three wait states, DMA port idle)
  logic        reset_b;
  logic        cpu_req_b, cpu_we_b;
  logic [15:0] cpu_addr_b;
  logic [7:0]  cpu_wdata_b;
  logic        dma_req_b = 1'b0, dma_we_b = 1'b0;
  logic [15:0] dma_addr_b = 16'h0;
  logic [7:0]  dma_wdata_b = 8'h0;
  logic        cpu_ack_b, dma_ack_b, mem_en_b, mem_we_b, busy_b;
  logic [7:0]  cpu_rdata_b, dma_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_arbiter #(.WAIT_STATES(0), .MEM_AW(8)) dut_a (
    .clk(clk), .reset(reset_a),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
    .cpu_ack(cpu_ack_a), .cpu_rdata(cpu_rdata_a),
    .dma_req(dma_req_a), .dma_we(dma_we_a), .dma_addr(dma_addr_a), .dma_wdata(dma_wdata_a),
    .dma_ack(dma_ack_a), .dma_rdata(dma_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_arbiter #(.WAIT_STATES(3), .MEM_AW(8)) dut_b (
    .clk(clk), .reset(reset_b),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
    .dma_req(dma_req_b), .dma_we(dma_we_b), .dma_addr(dma_addr_b), .dma_wdata(dma_wdata_b),
    .dma_ack(dma_ack_b), .dma_rdata(dma_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // Synchronous RAM models with a side preload port
  logic       pre_we_a = 1'b0, pre_we_b = 1'b0;
  logic [7:0] pre_addr = 8'h0, pre_data = 8'h0;
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];

  always @(posedge clk) begin
    if (pre_we_a) ram_a[pre_addr] <= pre_data;
    else if (mem_en_a) begin
      if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
      else          mem_rdata_a <= ram_a[mem_addr_a];
    end
  end

  always @(posedge clk) begin
    if (pre_we_b) ram_b[pre_addr] <= pre_data;
    else if (mem_en_b) begin
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      else          mem_rdata_b <= ram_b[mem_addr_b];
    end
  end

  task automatic preload(input bit sel_b, input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    if (sel_b) pre_we_b = 1'b1; else pre_we_a = 1'b1;
    @(posedge clk); #1;
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_ack_a !== 1'b0) begin fails++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack_a); end
    checks++; if (dma_ack_a !== 1'b0) begin fails++; $display("FAIL reset_dma_ack: got %b expected 0", dma_ack_a); end
    checks++; if (mem_en_a !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b expected 0", mem_en_a); end
    checks++; if (mem_we_a !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (cpu_rdata_a !== 8'h00) begin fails++; $display("FAIL reset_cpu_rdata: got %h expected 00", cpu_rdata_a); end
    checks++; if (dma_rdata_a !== 8'h00) begin fails++; $display("FAIL reset_dma_rdata: got %h expected 00", dma_rdata_a); end
    checks++; if (busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_cpu_read();
    preload(1'b0, 8'h12, 8'hA5);
    cpu_we_a = 1'b0; cpu_addr_a = 16'h0012; cpu_req_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_en_a !== 1'b1) begin fails++; $display("FAIL read_c1_mem_en: got %b expected 1", mem_en_a); end
    checks++; if (mem_we_a !== 1'b0) begin fails++; $display("FAIL read_c1_mem_we: got %b expected 0", mem_we_a); end
    checks++; if (mem_addr_a !== 8'h12) begin fails++; $display("FAIL read_c1_mem_addr: got %h expected 12", mem_addr_a); end
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL read_c1_busy: got %b expected 1", busy_a); end
    checks++; if (cpu_ack_a !== 1'b0) begin fails++; $display("FAIL read_c1_ack: got %b expected 0", cpu_ack_a); end
    @(posedge clk); #1;
    checks++; if (cpu_ack_a !== 1'b1) begin fails++; $display("FAIL read_c2_cpu_ack: got %b expected 1", cpu_ack_a); end
    checks++; if (dma_ack_a !== 1'b0) begin fails++; $display("FAIL read_c2_dma_ack: got %b expected 0", dma_ack_a); end
    checks++; if (mem_en_a !== 1'b0) begin fails++; $display("FAIL read_c2_mem_en: got %b expected 0", mem_en_a); end
    cpu_req_a = 1'b0;
    @(posedge clk); #1;
    checks++; if (cpu_rdata_a !== 8'hA5) begin fails++; $display("FAIL read_rdata: got %h expected a5", cpu_rdata_a); end
    checks++; if (cpu_ack_a !== 1'b0) begin fails++; $display("FAIL read_c3_ack: got %b expected 0", cpu_ack_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL read_c3_busy: got %b expected 0", busy_a); end
    checks++; if (dma_rdata_a !== 8'h00) begin fails++; $display("FAIL read_dma_rdata: got %h expected 00", dma_rdata_a); end
    $display("cpu_read: addr 0012 rdata %h", cpu_rdata_a);
  endtask

  task automatic test_wrap();
    dma_we_a = 1'b1; dma_addr_a = 16'h1F80; dma_wdata_a = 8'h3C; dma_req_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_en_a !== 1'b1) begin fails++; $display("FAIL wrap_w_mem_en: got %b expected 1", mem_en_a); end
    checks++; if (mem_we_a !== 1'b1) begin fails++; $display("FAIL wrap_w_mem_we: got %b expected 1", mem_we_a); end
    checks++; if (mem_addr_a !== 8'h80) begin fails++; $display("FAIL wrap_w_mem_addr: got %h expected 80", mem_addr_a); end
    checks++; if (mem_wdata_a !== 8'h3C) begin fails++; $display("FAIL wrap_w_mem_wdata: got %h expected 3c", mem_wdata_a); end
    @(posedge clk); #1;
    checks++; if (dma_ack_a !== 1'b1) begin fails++; $display("FAIL wrap_w_dma_ack: got %b expected 1", dma_ack_a); end
    checks++; if (cpu_ack_a !== 1'b0) begin fails++; $display("FAIL wrap_w_cpu_ack: got %b expected 0", cpu_ack_a); end
    dma_req_a = 1'b0; dma_we_a = 1'b0;
    @(posedge clk); #1;
    checks++; if (dma_rdata_a !== 8'h00) begin fails++; $display("FAIL wrap_w_rdata_hold: got %h expected 00", dma_rdata_a); end
    cpu_we_a = 1'b0; cpu_addr_a = 16'h0080; cpu_req_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_addr_a !== 8'h80) begin fails++; $display("FAIL wrap_r_mem_addr: got %h expected 80", mem_addr_a); end
    checks++; if (mem_we_a !== 1'b0) begin fails++; $display("FAIL wrap_r_mem_we: got %b expected 0", mem_we_a); end
    @(posedge clk); #1;
    checks++; if (cpu_ack_a !== 1'b1) begin fails++; $display("FAIL wrap_r_cpu_ack: got %b expected 1", cpu_ack_a); end
    cpu_req_a = 1'b0;
    @(posedge clk); #1;
    checks++; if (cpu_rdata_a !== 8'h3C) begin fails++; $display("FAIL wrap_r_rdata: got %h expected 3c", cpu_rdata_a); end
    $display("wrap: dma wrote 1f80, cpu read 0080 -> %h", cpu_rdata_a);
  endtask

  task automatic test_simultaneous();
    int cpu_cyc = -1, dma_cyc = -1, cpu_n = 0, dma_n = 0;
    int exp_cpu, exp_dma;
`ifdef MEM_ARB_RR_EN
    exp_cpu = 5; exp_dma = 2;
`else
    exp_cpu = 2; exp_dma = 5;
`endif
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    cpu_we_a = 1'b0; cpu_addr_a = 16'h0012; cpu_req_a = 1'b1;
    dma_we_a = 1'b0; dma_addr_a = 16'h0080; dma_req_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (cpu_ack_a) begin cpu_n++; if (cpu_cyc < 0) cpu_cyc = c; cpu_req_a = 1'b0; end
      if (dma_ack_a) begin dma_n++; if (dma_cyc < 0) dma_cyc = c; dma_req_a = 1'b0; end
    end
    checks++; if (cpu_cyc !== exp_cpu) begin fails++; $display("FAIL tie_cpu_ack_cycle: got %0d expected %0d", cpu_cyc, exp_cpu); end
    checks++; if (dma_cyc !== exp_dma) begin fails++; $display("FAIL tie_dma_ack_cycle: got %0d expected %0d", dma_cyc, exp_dma); end
    checks++; if (cpu_n !== 1) begin fails++; $display("FAIL tie_cpu_ack_count: got %0d expected 1", cpu_n); end
    checks++; if (dma_n !== 1) begin fails++; $display("FAIL tie_dma_ack_count: got %0d expected 1", dma_n); end
    checks++; if (cpu_rdata_a !== 8'hA5) begin fails++; $display("FAIL tie_cpu_rdata: got %h expected a5", cpu_rdata_a); end
    checks++; if (dma_rdata_a !== 8'h3C) begin fails++; $display("FAIL tie_dma_rdata: got %h expected 3c", dma_rdata_a); end
    $display("simultaneous: cpu ack cycle %0d, dma ack cycle %0d", cpu_cyc, dma_cyc);
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    cpu_we_a = 1'b0; cpu_addr_a = 16'h0012; cpu_req_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (cpu_ack_a) begin
        if (first < 0) first = c;
        else if (second < 0) begin second = c; cpu_req_a = 1'b0; end
      end
    end
    checks++; if (first !== 2) begin fails++; $display("FAIL b2b_first_ack: got %0d expected 2", first); end
    checks++; if (second !== 5) begin fails++; $display("FAIL b2b_second_ack: got %0d expected 5", second); end
    $display("back_to_back: acks at cycles %0d and %0d", first, second);
  endtask

  task automatic test_wait_states();
    int en_n = 0, en_cyc = -1, ack_cyc = -1;
    preload(1'b1, 8'h12, 8'hA5);
    cpu_we_b = 1'b0; cpu_addr_b = 16'h0012; cpu_wdata_b = 8'h00; cpu_req_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (mem_en_b) begin en_n++; en_cyc = c; end
      if (cpu_ack_b) begin ack_cyc = c; cpu_req_b = 1'b0; end
      if (c <= 4) begin
        checks++; if (busy_b !== 1'b1) begin fails++; $display("FAIL ws_busy_c%0d: got %b expected 1", c, busy_b); end
      end
      if (c == 6) begin
        checks++; if (busy_b !== 1'b0) begin fails++; $display("FAIL ws_busy_c6: got %b expected 0", busy_b); end
        checks++; if (cpu_rdata_b !== 8'hA5) begin fails++; $display("FAIL ws_rdata: got %h expected a5", cpu_rdata_b); end
      end
    end
    checks++; if (en_n !== 1) begin fails++; $display("FAIL ws_mem_en_count: got %0d expected 1", en_n); end
    checks++; if (en_cyc !== 1) begin fails++; $display("FAIL ws_mem_en_cycle: got %0d expected 1", en_cyc); end
    checks++; if (ack_cyc !== 5) begin fails++; $display("FAIL ws_ack_cycle: got %0d expected 5", ack_cyc); end
    $display("wait_states: mem_en cycles %0d, ack cycle %0d", en_n, ack_cyc);
  endtask

  task automatic test_reset_in_wait();
    int ack_cyc = -1, early_acks = 0;
    preload(1'b1, 8'h34, 8'h5A);
    cpu_we_b = 1'b0; cpu_addr_b = 16'h0034; cpu_req_b = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (cpu_ack_b) early_acks++;
    end
    checks++; if (busy_b !== 1'b1) begin fails++; $display("FAIL rst_wait_busy_before: got %b expected 1", busy_b); end
    reset_b = 1'b1;
    @(posedge clk); #1;
    checks++; if (early_acks !== 0) begin fails++; $display("FAIL rst_wait_early_ack: got %0d expected 0", early_acks); end
    checks++; if (cpu_ack_b !== 1'b0) begin fails++; $display("FAIL rst_wait_ack: got %b expected 0", cpu_ack_b); end
    checks++; if (busy_b !== 1'b0) begin fails++; $display("FAIL rst_wait_busy: got %b expected 0", busy_b); end
    checks++; if (mem_en_b !== 1'b0) begin fails++; $display("FAIL rst_wait_mem_en: got %b expected 0", mem_en_b); end
    checks++; if (mem_we_b !== 1'b0) begin fails++; $display("FAIL rst_wait_mem_we: got %b expected 0", mem_we_b); end
    checks++; if (cpu_rdata_b !== 8'h00) begin fails++; $display("FAIL rst_wait_rdata: got %h expected 00", cpu_rdata_b); end
    reset_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (cpu_ack_b && ack_cyc < 0) begin ack_cyc = c; cpu_req_b = 1'b0; end
    end
    checks++; if (ack_cyc !== 5) begin fails++; $display("FAIL rst_retry_ack_cycle: got %0d expected 5", ack_cyc); end
    checks++; if (cpu_rdata_b !== 8'h5A) begin fails++; $display("FAIL rst_retry_rdata: got %h expected 5a", cpu_rdata_b); end
    $display("reset_in_wait: retry ack cycle %0d rdata %h", ack_cyc, cpu_rdata_b);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    cpu_req_a = 1'b0; cpu_we_a = 1'b0; cpu_addr_a = 16'h0; cpu_wdata_a = 8'h0;
    dma_req_a = 1'b0; dma_we_a = 1'b0; dma_addr_a = 16'h0; dma_wdata_a = 8'h0;
    cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_addr_b = 16'h0; cpu_wdata_b = 8'h0;
    test_reset();
    test_cpu_read();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_wait_states();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
